// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW-hazard detector for the ID stage of the pipelined core.
// A DEPTH-entry shift scoreboard holds the destination registers that are
// still in flight. Every ID-stage source is compared against all valid
// entries. The block drives the ID stall and counts stalled cycles.
// Optional feature macro: HAZARD_SCOREBOARD_FWD_EN. When it is defined,
// a forwarding network is assumed, and only a load-use on entry 0 stalls.
module hazard_scoreboard #(
    parameter int REG_W = 3,
    parameter int DEPTH = 4,
    parameter int NSRC  = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wr,
    input  logic [REG_W-1:0]      issue_rd,
    input  logic                  issue_ld,
    input  logic [NSRC-1:0]       rs_valid,
    input  logic [NSRC*REG_W-1:0] rs_addr,
    input  logic                  flush,
    output logic [NSRC-1:0]       hit,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Scoreboard entries: entry 0 = ID/EX, entry DEPTH-1 = oldest.
    logic [DEPTH-1:0] sb_v;
    logic [REG_W-1:0] sb_rd [DEPTH];
    logic [DEPTH-1:0] sb_ld;

    // The counter stays at all-ones once it gets there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Per-source match against any valid entry. Duplicate matches collapse to one bit.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (sb_v[k] && (sb_rd[k] == rs_addr[i*REG_W +: REG_W]))
                    hit[i] = rs_valid[i];
            end
        end
    end

`ifdef HAZARD_SCOREBOARD_FWD_EN
    logic ld_use;

    // Forwarding covers ALU results. Only a load still in ID/EX cannot be bypassed.
    always_comb begin
        ld_use = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (rs_valid[i] && sb_v[0] && sb_ld[0] &&
                (sb_rd[0] == rs_addr[i*REG_W +: REG_W]))
                ld_use = 1'b1;
        end
        stall = issue_valid & ~flush & ld_use;
    end
`else
    logic ld_unused;

    // Full interlock: any in-flight producer of a read source holds ID.
    always_comb begin
        stall     = issue_valid & (|hit) & ~flush;
        ld_unused = ^sb_ld;
    end
`endif

    // Valid bits shift every cycle. Flush or stall put a bubble into entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++)
                sb_v[k] <= sb_v[k-1];
            sb_v[0] <= (flush || stall) ? 1'b0 : (issue_valid & issue_wr);
        end
    end

    // Payload shifts unconditionally. A bubble's payload is ignored because its v is 0.
    always_ff @(posedge clk) begin
        for (int k = 1; k < DEPTH; k++) begin
            sb_rd[k] <= sb_rd[k-1];
            sb_ld[k] <= sb_ld[k-1];
        end
        sb_rd[0] <= issue_rd;
        sb_ld[0] <= issue_ld;
    end

    // Saturating count of stalled cycles. Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised RAW-hazard detector for the pipelined core.
- Tracks in-flight destination registers in an internal shift scoreboard (one entry per downstream stage) and compares every ID-stage source address against all valid entries.
- Drives the ID-stage stall and inserts bubbles into its own scoreboard while stalled. Counts total stall cycles for performance visibility.

Parameters:
- REG_W, 3, register address width (8-entry register file)
- DEPTH, 4, number of tracked in-flight stages (entry 0 = ID/EX ... entry DEPTH-1 = oldest); legal range 1..8
- NSRC, 2, number of source operands checked per instruction
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  ID stage holds a real instruction this cycle
- issue_wr  in  1  ID instruction writes a register
- issue_rd  in  REG_W  ID instruction destination address
- issue_ld  in  1  ID instruction is a load
- rs_valid  in  NSRC  per-source "operand is read" flag
- rs_addr  in  NSRC*REG_W  source addresses; source i at bits [i*REG_W +: REG_W]
- flush  in  1  squash the ID instruction and scoreboard entry 0 (branch redirect)
- hit  out  NSRC  per-source match against any valid scoreboard entry
- stall  out  1  hold PC and IF/ID, bubble ID/EX
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Scoreboard: DEPTH entries of {v, rd[REG_W-1:0], ld}, all registered. The reset value of every v is 0; rd and ld are don't-care.
- hit[i] (combinational): rs_valid[i] & OR over k of (v[k] & rd[k]==rs_addr[i]).
- stall (combinational): issue_valid & |hit & ~flush. Per the gating terms, stall=0 whenever issue_valid=0 or flush=1.
- Update on each clk edge, priority rst > flush > stall > normal:
  - rst: all v<=0, stall_cnt<=0.
  - flush: entry 0 v<=0. Entries 1..DEPTH-1 shift normally from entries 0..DEPTH-2, so the pre-flush entry 0 still advances. The issue is discarded.
  - stall: entries k>=1 take entry k-1. Entry 0 takes a bubble (v=0).
  - normal: entries shift. Entry 0 takes {issue_valid&issue_wr, issue_rd, issue_ld}.
  - The oldest entry falls off the end each cycle.
- Stall length: a dependence on entry k drains in DEPTH-k cycles. Maximum continuous stall is DEPTH cycles with no external help.
- Multiple matches: hit[i] is set once, regardless of how many entries match. The same register held in several entries is legal.
- One instruction may match both sources, and the sources may match each other. Both hit bits assert.
- issue_wr=0 or issue_valid=0 on a non-stalled cycle inserts a v=0 entry.
- stall_cnt: increments by 1 on every edge where stall=1 and rst=0. It saturates at all-ones and clears only on rst.
- Reset mid-stall: stall drops in the cycle after the rst edge, because the scoreboard is empty. No residual bubbles are tracked.
- Register 0 is a real register (no hardwired zero). r0 matches like any other address.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_FWD_EN.
- Defined: a forwarding network exists. stall = issue_valid & ~flush & OR over i of (rs_valid[i] & v[0] & ld[0] & rd[0]==rs_addr[i]). This is load-use on entry 0 only, giving a 1-cycle stall. hit[] still reports all matches, for the forwarding mux select.
- Not defined: full-interlock behaviour described above.
- Scoreboard update and stall_cnt rules are identical in both builds.

Test Plan:
- Reset: hold rst=1 for 2 cycles with issue_valid=1, rs_addr={r3,r3} -> hit=0, stall=0, stall_cnt=0 after release.
- Back-to-back RAW, default build, DEPTH=4: cycle 0 issue wr r3; cycle 1 issue reads r3 -> stall=1 for cycles 1-4, 0 in cycle 5; stall_cnt=4.
- Distance-2 RAW: wr r5, then an independent instruction, then read r5 -> stall for exactly 3 cycles; hit[1] alone set when r5 is on source 1.
- Flush during stall: wr r2, then read r2 with flush=1 in cycle 1 -> stall=0 in cycle 1, entry 0 cleared. The r2 entry still drains, and a later read of r2 in cycle 2 stalls 3 cycles.
- Saturation: CNT_W=4, force 20 stall cycles -> stall_cnt holds 15; rst -> 0.
- FWD_EN build: load to r4, then add reading r4 -> exactly 1 stall cycle, hit=01 in both cycles. ALU wr r4, then read r4 -> stall=0, hit=01.
